fifo_param: RTL and testbench
=============================

# fifo_param

Parameterised synchronous FIFO, the successor to the fixed 8 x 32-bit FIFO. Data width, depth and almost-full/almost-empty thresholds are configurable. It keeps the per-request handshake pulses and the occupancy count. It adds four things: defined simultaneous read/write behaviour at full and at empty, a synchronous flush, almost-full/almost-empty flags, and a high-water-mark output. It sits between producer and consumer blocks in the same clock domain.

## Interface
- DATA_WIDTH, 32, width of d_in/d_out
- ADDR_WIDTH, 3, depth = 2^ADDR_WIDTH entries (min 1)
- AF_LEVEL, 6, almost_full asserts when data_count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when data_count <= AE_LEVEL
- clk  input  1  clock; all logic is rising-edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of contents
- wr_en  input  1  write request
- rd_en  input  1  read request
- d_in  input  DATA_WIDTH  write data
- d_out  output  DATA_WIDTH  last successfully read word (registered)
- data_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- full / empty  output  1  data_count == DEPTH / data_count == 0
- almost_full / almost_empty  output  1  threshold flags derived from data_count
- wr_ack / wr_err  output  1  registered pulse: the write was accepted / rejected
- rd_ack / rd_err  output  1  registered pulse: the read was accepted / rejected
- high_water  output  ADDR_WIDTH+1  maximum data_count since reset

## Operation
- Storage: DEPTH x DATA_WIDTH register array.
  - wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
  - data_count is a separate register.
- Priority at each edge: reset > flush > rd/wr.
- Reset sets:
  - pointers, data_count, high_water to 0
  - d_out to 0
  - all ack/err to 0
  - empty=1, almost_empty=1, full=0, almost_full=0
- Flush sets:
  - pointers and data_count to 0
  - all ack/err to 0 on that edge; rd_en/wr_en on that edge are ignored
  - d_out and high_water are held
- Read accept: rd_en && !empty (evaluated on data_count before the edge).
  - d_out <= mem[rd_ptr]; rd_ptr++; rd_ack=1.
- Read reject: rd_en && empty.
  - rd_err=1; d_out holds; no pointer change.
- Write accept: wr_en && (!full || read accepted on the same edge).
  - mem[wr_ptr] <= d_in; wr_ptr++; wr_ack=1.
- Write reject: otherwise with wr_en.
  - wr_err=1; memory unchanged.
- Simultaneous rd_en and wr_en:
  - Full: both accepted; count unchanged; d_out = oldest word.
  - Empty: write accepted, read rejected (rd_err); count becomes 1. No read-through.
  - Otherwise: both accepted; count unchanged.
- data_count next value: +1 for write-only accept, -1 for read-only accept, unchanged otherwise.
- high_water <= max(high_water, next data_count).
- Requires AE_LEVEL < AF_LEVEL <= DEPTH.

## Timing
- All outputs are registered, or decoded from registered data_count only. No combinational path from inputs to outputs.
- ack/err pulses last exactly one cycle, in the cycle after the sampling edge. Back-to-back requests produce continuous assertion.
- Read latency: d_out is valid in the cycle after the edge that sampled rd_en.
- Write-to-read: a word written at edge N is readable at edge N+1. full, empty, almost_* and data_count update in the cycle after edge N.
- Reset or flush asserted mid-burst takes effect at that edge; the next cycle shows the empty state.

## Test plan
- Reset, then rd_en for 1 cycle -> rd_err=1 for 1 cycle, rd_ack=0, d_out=0, data_count=0, empty=1.
- Write 0x11,0x22,...,0xBB (11 consecutive cycles, rd_en=0):
  - wr_ack for the first 8 writes, wr_err for the last 3
  - almost_full rises after the 6th write
  - full=1 and data_count=8, high_water=8
  - memory holds 0x11..0x88
- From full, rd_en for 3 cycles -> d_out 0x11, 0x22, 0x33 on successive cycles; data_count 5; full=0; almost_full=0.
- Simultaneous access at the boundaries:
  - At full: rd_en=wr_en=1 with d_in=0xCC -> rd_ack=wr_ack=1, count stays 8, d_out=oldest word.
  - At empty: rd_en=wr_en=1 with d_in=0xDD -> wr_ack=1, rd_err=1, count=1, almost_empty=1.
  - At empty, the next read -> d_out=0xDD.
- Wrap-around: 20 interleaved write/read pairs with incrementing data, count oscillating 0..3 -> read order exactly matches write order across pointer wrap; no ack/err mismatch.
- Flush with count=5 and wr_en=1 on the same edge -> next cycle: count=0, empty=1, wr_ack=0, d_out and high_water held. A subsequent read gives rd_err.

Source files
------------

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parameterised synchronous FIFO with flush, threshold flags and high-water mark
module fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [ADDR_WIDTH:0]   high_water
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_high_water;
    logic [DATA_WIDTH-1:0] r_d_out;
    logic                  r_wr_ack;
    logic                  r_wr_err;
    logic                  r_rd_ack;
    logic                  r_rd_err;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Status flags decode only the registered occupancy, so no input reaches an output combinationally.
    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // A read frees a slot on the same edge, so a full FIFO can still take a paired write;
    // an empty FIFO never reads through the word being written.
    assign w_rd_acc = rd_en && !w_empty;
    assign w_wr_acc = wr_en && (!w_full || w_rd_acc);

    // Occupancy only moves when exactly one side is accepted.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + (ADDR_WIDTH + 1)'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - (ADDR_WIDTH + 1)'(1);
        end
    end

    // Storage array; writes are suppressed on reset and flush edges.
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_wr_acc) begin
            r_mem[r_wr_ptr] <= d_in;
        end
    end

    // Pointers, occupancy, read data, handshake pulses and high-water tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_high_water <= '0;
            r_d_out      <= '0;
            r_wr_ack     <= 1'b0;
            r_wr_err     <= 1'b0;
            r_rd_ack     <= 1'b0;
            r_rd_err     <= 1'b0;
        end else if (flush) begin
            // Contents are discarded but the last read word and high-water mark survive.
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_wr_ack     <= 1'b0;
            r_wr_err     <= 1'b0;
            r_rd_ack     <= 1'b0;
            r_rd_err     <= 1'b0;
        end else begin
            r_wr_ack <= w_wr_acc;
            r_wr_err <= wr_en && !w_wr_acc;
            r_rd_ack <= w_rd_acc;
            r_rd_err <= rd_en && !w_rd_acc;
            if (w_rd_acc) begin
                r_d_out  <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            r_count <= w_count_nxt;
            if (w_count_nxt > r_high_water) begin
                r_high_water <= w_count_nxt;
            end
        end
    end

    assign d_out        = r_d_out;
    assign data_count   = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_AF);
    assign almost_empty = (r_count <= C_AE);
    assign wr_ack       = r_wr_ack;
    assign wr_err       = r_wr_err;
    assign rd_ack       = r_rd_ack;
    assign rd_err       = r_rd_err;
    assign high_water   = r_high_water;

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed self-checking bench for fifo_param
module tb_fifo_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic [3:0]  data_count;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_ack;
    logic        rd_err;
    logic [3:0]  high_water;

    int checks   = 0;
    int failures = 0;

    fifo_param #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(3),
        .AF_LEVEL(6),
        .AE_LEVEL(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .d_in(d_in),
        .d_out(d_out),
        .data_count(data_count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .wr_ack(wr_ack),
        .wr_err(wr_err),
        .rd_ack(rd_ack),
        .rd_err(rd_err),
        .high_water(high_water)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] q[$];
    logic [31:0] exp_word;
    logic [31:0] last_rd;
    int          written;
    int          fill_phase;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        d_in  = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_count", 32'(data_count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_dout", d_out, 32'd0);
        chk("rst_hw", 32'(high_water), 32'd0);
        chk("rst_acks", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);

        // Read while empty
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("empty_rd_err", 32'(rd_err), 32'd1);
        chk("empty_rd_ack", 32'(rd_ack), 32'd0);
        chk("empty_rd_dout", d_out, 32'd0);
        chk("empty_rd_count", 32'(data_count), 32'd0);
        chk("empty_rd_empty", 32'(empty), 32'd1);
        tick();
        chk("rd_err_pulse", 32'(rd_err), 32'd0);

        // Eleven writes into an 8-deep FIFO
        for (int i = 0; i < 11; i++) begin
            wr_en = 1'b1;
            d_in  = 32'((i + 1) * 32'h11);
            tick();
            chk("fill_wr_ack", 32'(wr_ack), 32'(i < 8));
            chk("fill_wr_err", 32'(wr_err), 32'(i >= 8));
            chk("fill_afull", 32'(almost_full), 32'(i >= 5));
            chk("fill_aempty", 32'(almost_empty), 32'(i <= 1));
        end
        wr_en = 1'b0;
        tick();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(data_count), 32'd8);
        chk("fill_hw", 32'(high_water), 32'd8);
        chk("fill_ack_drop", 32'(wr_ack), 32'd0);

        // Three reads from full
        for (int k = 0; k < 3; k++) begin
            rd_en = 1'b1;
            tick();
            chk("drain3_dout", d_out, 32'((k + 1) * 32'h11));
            chk("drain3_ack", 32'(rd_ack), 32'd1);
        end
        rd_en = 1'b0;
        tick();
        chk("drain3_count", 32'(data_count), 32'd5);
        chk("drain3_full", 32'(full), 32'd0);
        chk("drain3_afull", 32'(almost_full), 32'd0);

        // Refill to full: 0xE1..0xE3 after 0x44..0x88
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1;
            d_in  = 32'hE1 + 32'(k);
            tick();
        end
        wr_en = 1'b0;
        chk("refill_full", 32'(full), 32'd1);

        // Simultaneous read and write at full
        rd_en = 1'b1;
        wr_en = 1'b1;
        d_in  = 32'hCC;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        chk("full_rw_rd_ack", 32'(rd_ack), 32'd1);
        chk("full_rw_wr_ack", 32'(wr_ack), 32'd1);
        chk("full_rw_count", 32'(data_count), 32'd8);
        chk("full_rw_dout", d_out, 32'h44);

        // Drain everything and check order
        q = '{32'h55, 32'h66, 32'h77, 32'h88, 32'hE1, 32'hE2, 32'hE3, 32'hCC};
        while (q.size() > 0) begin
            exp_word = q.pop_front();
            rd_en = 1'b1;
            tick();
            chk("drain_all_dout", d_out, exp_word);
        end
        rd_en = 1'b0;
        tick();
        chk("drain_all_empty", 32'(empty), 32'd1);

        // Simultaneous read and write at empty
        rd_en = 1'b1;
        wr_en = 1'b1;
        d_in  = 32'hDD;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        chk("empty_rw_wr_ack", 32'(wr_ack), 32'd1);
        chk("empty_rw_rd_err", 32'(rd_err), 32'd1);
        chk("empty_rw_rd_ack", 32'(rd_ack), 32'd0);
        chk("empty_rw_count", 32'(data_count), 32'd1);
        chk("empty_rw_aempty", 32'(almost_empty), 32'd1);
        chk("empty_rw_dout", d_out, 32'hCC);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("after_rw_dout", d_out, 32'hDD);
        chk("after_rw_count", 32'(data_count), 32'd0);

        // Wrap-around: fill to 3, drain to 0, repeat until 20 words passed through
        written    = 0;
        fill_phase = 1;
        q.delete();
        while (written < 20 || q.size() > 0) begin
            if (fill_phase != 0 && written < 20) begin
                wr_en = 1'b1;
                d_in  = 32'h100 + 32'(written);
                q.push_back(d_in);
                written++;
                tick();
                wr_en = 1'b0;
                chk("wrap_wr_ack", 32'({wr_ack, wr_err}), 32'b10);
                if (q.size() == 3 || written == 20) fill_phase = 0;
            end else begin
                exp_word = q.pop_front();
                rd_en = 1'b1;
                tick();
                rd_en = 1'b0;
                chk("wrap_rd_ack", 32'({rd_ack, rd_err}), 32'b10);
                chk("wrap_dout", d_out, exp_word);
                if (q.size() == 0) fill_phase = 1;
            end
            chk("wrap_count", 32'(data_count), 32'(q.size()));
        end
        last_rd = 32'h100 + 32'd19;

        // Flush with five words stored and a write on the same edge
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1;
            d_in  = 32'hA0 + 32'(k);
            tick();
        end
        wr_en = 1'b0;
        chk("preflush_count", 32'(data_count), 32'd5);
        flush = 1'b1;
        wr_en = 1'b1;
        d_in  = 32'hFF;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        chk("flush_count", 32'(data_count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_wr_ack", 32'(wr_ack), 32'd0);
        chk("flush_dout", d_out, last_rd);
        chk("flush_hw", 32'(high_water), 32'd8);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("postflush_rd_err", 32'(rd_err), 32'd1);
        chk("postflush_dout", d_out, last_rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
